// File: rtl/pll_lock_mgr.sv
// PLL lock supervisor: synchronises and debounces the raw PLL lock flag, holds the
// system reset for a fixed time after lock, and requests a PLL relock on timeout.
module pll_lock_mgr #(
  parameter int SYNC_STAGES     = 2,
  parameter int STABLE_CYCLES   = 1024,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 65536,
  parameter int RELOCK_PULSE    = 8,
  parameter int CNT_W           = 8
) (
  input  logic             clock_in,
  input  logic             rst_in,
  input  logic             lock_in,
  output logic             locked,
  output logic             rst_out,
  output logic             pll_rst_req,
  output logic [CNT_W-1:0] loss_count,
  output logic [CNT_W-1:0] relock_count
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYCLES = max2(max2(STABLE_CYCLES, RST_HOLD_CYCLES),
                                   max2(TIMEOUT_CYCLES, RELOCK_PULSE));
  localparam int CW = $clog2(MAX_CYCLES) + 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST    = CW'(RST_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LAST   = CW'(RELOCK_PULSE - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_WAIT, S_STABLE, S_HOLD, S_RUN, S_PLLRST
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic             lock_s;
  logic             locked_reg, locked_next;
  logic             rst_out_reg, rst_out_next;
  logic             req_reg, req_next;
  logic [CNT_W-1:0] loss_reg, loss_next;
  logic [CNT_W-1:0] relock_reg, relock_next;

  assign lock_s = sync_reg[SYNC_STAGES-1];

  // State register; the output flops live here too so every output is a flop.
  always_ff @(posedge clock_in or posedge rst_in) begin
    if (rst_in) begin
      sync_reg    <= '0;
      state_reg   <= S_WAIT;
      count_reg   <= '0;
      locked_reg  <= 1'b0;
      rst_out_reg <= 1'b1;
      req_reg     <= 1'b0;
      loss_reg    <= '0;
      relock_reg  <= '0;
    end else begin
      sync_reg    <= {sync_reg[SYNC_STAGES-2:0], lock_in};
      state_reg   <= state_next;
      count_reg   <= count_next;
      locked_reg  <= locked_next;
      rst_out_reg <= rst_out_next;
      req_reg     <= req_next;
      loss_reg    <= loss_next;
      relock_reg  <= relock_next;
    end
  end

  // One shared timer/counter: each state only ever needs one of them.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      S_WAIT: begin
        if (lock_s) begin
          state_next = S_STABLE;
          count_next = '0;
        end else if (TIMEOUT_EN && count_reg == TIMEOUT_LAST) begin
          state_next = S_PLLRST;
          count_next = '0;
        end else if (TIMEOUT_EN) begin
          count_next = count_reg + 1'b1;
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_next = S_WAIT;
          count_next = '0;
        end else if (count_reg == STABLE_LAST) begin
          state_next = S_HOLD;
          count_next = '0;
        end else begin
          count_next = count_reg + 1'b1;
        end
      end
      S_HOLD: begin
        if (!lock_s) begin
          state_next = S_WAIT;
          count_next = '0;
        end else if (count_reg == HOLD_LAST) begin
          state_next = S_RUN;
          count_next = '0;
        end else begin
          count_next = count_reg + 1'b1;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_next = S_WAIT;
          count_next = '0;
        end
      end
      S_PLLRST: begin
        if (count_reg == PULSE_LAST) begin
          state_next = S_WAIT;
          count_next = '0;
        end else begin
          count_next = count_reg + 1'b1;
        end
      end
      default: begin
        state_next = S_WAIT;
        count_next = '0;
      end
    endcase
  end

  always_comb begin
    locked_next  = (state_next == S_HOLD) || (state_next == S_RUN);
    rst_out_next = (state_next != S_RUN);
    req_next     = (state_next == S_PLLRST);
    loss_next    = loss_reg;
    relock_next  = relock_reg;
    if ((state_reg == S_HOLD || state_reg == S_RUN) && state_next == S_WAIT && loss_reg != CNT_MAX)
      loss_next = loss_reg + 1'b1;
    if (state_reg == S_WAIT && state_next == S_PLLRST && relock_reg != CNT_MAX)
      relock_next = relock_reg + 1'b1;
  end

  assign locked       = locked_reg;
  assign rst_out      = rst_out_reg;
  assign pll_rst_req  = req_reg;
  assign loss_count   = loss_reg;
  assign relock_count = relock_reg;

endmodule

// File: doc/pll_lock_mgr.md
# pll_lock_mgr

Parametrised PLL lock supervisor and reset generator. It runs in the PLL output clock domain and turns the raw asynchronous PLL lock flag into three things: a debounced `locked` qualifier, a system reset with a fixed hold time, and a PLL re-lock request when lock never arrives. It replaces the bare two-flop lock synchroniser behind each CC_PLL/CC_BUFG pair and adds stability filtering, loss-of-lock handling, a timeout-driven relock and event counters.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser depth for `lock_in`; must be ≥2.
- `STABLE_CYCLES`, 1024: consecutive synchronised-high cycles required before lock is declared; must be ≥1.
- `RST_HOLD_CYCLES`, 16: cycles `rst_out` stays high after `locked` rises; must be ≥1.
- `TIMEOUT_CYCLES`, 65536: cycles spent in WAIT without lock before a relock is requested; 0 disables the timeout.
- `RELOCK_PULSE`, 8: width of the `pll_rst_req` pulse in cycles; must be ≥1.
- `CNT_W`, 8: width of the event counters.

Ports:
- `clock_in` in 1: the single clock (buffered PLL output).
- `rst_in` in 1: reset, asynchronous, active-high.
- `lock_in` in 1: raw PLL lock (USR_PLL_LOCKED), asynchronous to `clock_in`.
- `locked` out 1: lock qualified and stable.
- `rst_out` out 1: active-high system reset, released synchronously.
- `pll_rst_req` out 1: PLL reset/relock pulse.
- `loss_count` out CNT_W: lock-loss events, saturating.
- `relock_count` out CNT_W: timeout relock requests, saturating.

## Operation
- Reset values, applied asynchronously while `rst_in`=1: state WAIT; all sync flops 0; `locked`=0; `rst_out`=1; `pll_rst_req`=0; both counters 0; all internal timers 0.
- `lock_s` is `lock_in` after SYNC_STAGES flops. Only `lock_s` is used.
- WAIT (`locked`=0, `rst_out`=1):
  - `lock_s`=1: go to STABLE, cnt=0.
  - Otherwise, when timer==TIMEOUT_CYCLES-1: go to PLLRST, `pll_rst_req`<=1, `relock_count`++.
  - Otherwise: timer++.
  - If `lock_s`=1 on the terminal timer cycle, STABLE wins.
- STABLE:
  - `lock_s`=0: go to WAIT, timer=0.
  - `lock_s`=1 and cnt==STABLE_CYCLES-1: go to HOLD, `locked`<=1, cnt=0.
  - Otherwise: cnt++.
- HOLD (`locked`=1, `rst_out`=1): when cnt==RST_HOLD_CYCLES-1, go to RUN and `rst_out`<=0; otherwise cnt++.
- RUN (`locked`=1, `rst_out`=0): stays until lock is lost.
- Loss, in HOLD or RUN: `lock_s`=0 takes priority over everything else. On that edge `locked`<=0, `rst_out`<=1, `loss_count`++, go to WAIT, timer=0.
- PLLRST: `lock_s` is ignored.
  - When cnt==RELOCK_PULSE-1: `pll_rst_req`<=0, go to WAIT, timer=0.
  - Otherwise: cnt++.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Timer and counter width: $clog2 of the largest of STABLE_CYCLES, RST_HOLD_CYCLES, TIMEOUT_CYCLES and RELOCK_PULSE, plus 1.
- All outputs are registered directly from flops; none is combinational.

## Timing
- Lock acquire: `lock_in` first sampled high on edge 1 and held. `lock_s` goes high after edge SYNC_STAGES. `locked` goes high after edge SYNC_STAGES+STABLE_CYCLES+1.
- Reset release: `rst_out` falls RST_HOLD_CYCLES edges after `locked` rises.
- Lock loss: `lock_in` falls, and `locked`/`rst_out` react SYNC_STAGES+1 edges later on the same edge. `loss_count` updates on that same edge.
- Timeout: the relock pulse starts TIMEOUT_CYCLES edges after entering WAIT. Relock period with no lock is TIMEOUT_CYCLES+RELOCK_PULSE.
- Reset mid-operation: all outputs return to reset values with no clock edge required. Operation restarts from WAIT on the first edge after `rst_in` falls.

## Test plan
Bench parameters: SYNC_STAGES=2, STABLE_CYCLES=8, RST_HOLD_CYCLES=4, TIMEOUT_CYCLES=32, RELOCK_PULSE=3, CNT_W=2.
- Clean lock: `lock_in`=1 from edge 1 → `locked` rises after edge 11, `rst_out` falls after edge 15, `pll_rst_req` stays 0, both counters stay 0.
- Glitchy lock: `lock_in` high 5 cycles, low 1, then steady → `locked` rises 11 edges after the steady rise, never earlier; `loss_count`=0.
- Loss in RUN: drop `lock_in` → `locked`=0 and `rst_out`=1 3 edges later, `loss_count`=1. Four acquire/loss cycles → `loss_count` saturates at 3.
- Timeout: `lock_in` held 0 after reset → `pll_rst_req` high after edge 32 for exactly 3 cycles, repeating every 35 cycles. `relock_count` reads 1, 2, 3, 3.
- Simultaneous: `lock_s` rises on the terminal timeout cycle (edge 32) → state goes to STABLE, no `pll_rst_req` pulse, `relock_count` unchanged.
- Async reset during HOLD: `rst_in` pulse between edges → `locked`=0, `rst_out`=1 and counters 0 immediately. A full re-acquire follows (11 edges).
